// File: rtl/vga_scan_ctrl_pkg.sv
// vga_scan_pkg
//
// Shared definitions for the raster scan controller: default 640x480@60
// timing constants, the derived line/frame totals, the coordinate widths
// and the scan phase enumeration used by both the horizontal and the
// vertical phase counters.
//
// Optional feature macro used elsewhere in this slice: SCAN_TILE_EN.

package vga_scan_pkg;

    // Coordinate and tile index widths.
    localparam int unsigned COORD_W = 16;
    localparam int unsigned TILE_W  = 13;

    // Default horizontal timing, in pixels.
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    // Default vertical timing, in lines.
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Phase of one scan axis: visible region, front porch, sync, back porch.
    typedef enum logic [1:0] {
        ACT = 2'd0,
        FP  = 2'd1,
        SYN = 2'd2,
        BP  = 2'd3
    } scan_phase_t;

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// vga_scan_ctrl_if
//
// Bundles the pixel enable and every scan output of vga_scan_ctrl.
//   pix_en      pixel advance enable (into the controller)
//   col, row    current scan position
//   hsync,vsync active-low sync levels
//   active      visible-region flag
//   line_tick   one-clock pulse when col wraps to 0
//   frame_tick  one-clock pulse when col and row both wrap to 0
//   tile_col, tile_row, tile_start   8x8 tile outputs (SCAN_TILE_EN only)
//
// Modports: master = the scan controller, slave = the environment that
// supplies pix_en and consumes the coordinates.
// Optional feature macro: SCAN_TILE_EN.

interface vga_scan_ctrl_if;
    import vga_scan_pkg::*;

    logic               pix_en;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic               hsync;
    logic               vsync;
    logic               active;
    logic               line_tick;
    logic               frame_tick;
`ifdef SCAN_TILE_EN
    logic [TILE_W-1:0]  tile_col;
    logic [TILE_W-1:0]  tile_row;
    logic               tile_start;
`endif

    modport master (
        input  pix_en,
        output col, row, hsync, vsync, active, line_tick, frame_tick
`ifdef SCAN_TILE_EN
        , output tile_col, tile_row, tile_start
`endif
    );

    modport slave (
        output pix_en,
        input  col, row, hsync, vsync, active, line_tick, frame_tick
`ifdef SCAN_TILE_EN
        , input tile_col, tile_row, tile_start
`endif
    );

endinterface

// File: rtl/vga_scan_ctrl_scan_phase_counter.sv
// scan_phase_counter
//
// One scan axis: a position counter 0..TOTAL-1 plus a phase FSM
// (ACT -> FP -> SYN -> BP -> ACT). Both advance only when adv_i is high.
// All outputs describe the NEXT state so the parent can register them
// alongside the coordinate and keep every output aligned.
//   clk, rst        clock, asynchronous active-high reset
//   adv_i           advance one position this clock
//   cnt_nxt_o       position after this clock
//   active_nxt_o    next phase is ACT
//   sync_nxt_o      next phase is SYN (active-high here; parent inverts)
//   wrap_o          this clock advances from TOTAL-1 back to 0

module scan_phase_counter
    import vga_scan_pkg::*;
#(
    parameter int unsigned ACT_LEN  = H_ACTIVE_DEF,
    parameter int unsigned FP_LEN   = H_FP_DEF,
    parameter int unsigned SYNC_LEN = H_SYNC_DEF,
    parameter int unsigned BP_LEN   = H_BP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv_i,
    output logic [COORD_W-1:0] cnt_nxt_o,
    output logic               active_nxt_o,
    output logic               sync_nxt_o,
    output logic               wrap_o
);

    localparam int unsigned TOTAL = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN;

    // Last position of each phase; the phase changes on the advance that
    // leaves this position.
    localparam logic [COORD_W-1:0] ACT_END = COORD_W'(ACT_LEN - 1);
    localparam logic [COORD_W-1:0] FP_END  = COORD_W'(ACT_LEN + FP_LEN - 1);
    localparam logic [COORD_W-1:0] SYN_END = COORD_W'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
    localparam logic [COORD_W-1:0] LAST    = COORD_W'(TOTAL - 1);

    logic [COORD_W-1:0] cnt_q, cnt_d;
    scan_phase_t        phase_q, phase_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= ACT;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Next position and phase. Without adv_i everything holds, so the
    // next-state decodes equal the current ones and the parent's levels
    // stay frozen.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        wrap_o  = adv_i && (cnt_q == LAST);

        if (adv_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            unique case (phase_q)
                ACT: if (cnt_q == ACT_END) phase_d = FP;
                FP:  if (cnt_q == FP_END)  phase_d = SYN;
                SYN: if (cnt_q == SYN_END) phase_d = BP;
                BP:  if (cnt_q == LAST)    phase_d = ACT;
                default:                   phase_d = ACT;
            endcase
        end

        cnt_nxt_o    = cnt_d;
        active_nxt_o = (phase_d == ACT);
        sync_nxt_o   = (phase_d == SYN);
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
//
// Raster scan controller. Generates the registered col/row scan position
// plus hsync/vsync (active-low), active, line_tick and frame_tick, all
// taken from one flop bank loaded from next-state values so no output is
// skewed against the coordinates.
//   clk, rst   clock, asynchronous active-high reset
//   scan       vga_scan_ctrl_if.master: pix_en in; col, row, hsync, vsync,
//              active, line_tick, frame_tick out (and tile_col, tile_row,
//              tile_start when SCAN_TILE_EN is defined)
//
// Optional feature macro: SCAN_TILE_EN adds 8x8 tile indices and a
// tile_start flag, registered and aligned with col/row.

module vga_scan_ctrl
    import vga_scan_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    vga_scan_ctrl_if.master scan
);

    logic [COORD_W-1:0] hCntNxt, vCntNxt;
    logic               hActNxt, vActNxt;
    logic               hSyncNxt, vSyncNxt;
    logic               hWrap, vWrap;

    // Horizontal axis steps on every pixel enable.
    scan_phase_counter #(
        .ACT_LEN  (H_ACTIVE),
        .FP_LEN   (H_FP),
        .SYNC_LEN (H_SYNC),
        .BP_LEN   (H_BP)
    ) hCounter (
        .clk          (clk),
        .rst          (rst),
        .adv_i        (scan.pix_en),
        .cnt_nxt_o    (hCntNxt),
        .active_nxt_o (hActNxt),
        .sync_nxt_o   (hSyncNxt),
        .wrap_o       (hWrap)
    );

    // Vertical axis steps only when a line wraps.
    scan_phase_counter #(
        .ACT_LEN  (V_ACTIVE),
        .FP_LEN   (V_FP),
        .SYNC_LEN (V_SYNC),
        .BP_LEN   (V_BP)
    ) vCounter (
        .clk          (clk),
        .rst          (rst),
        .adv_i        (hWrap),
        .cnt_nxt_o    (vCntNxt),
        .active_nxt_o (vActNxt),
        .sync_nxt_o   (vSyncNxt),
        .wrap_o       (vWrap)
    );

    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic               active_q, active_d;
    logic               line_tick_q, line_tick_d, frame_tick_q, frame_tick_d;

    // Output next-state. A wrap only happens on an enabled clock, so the
    // ticks are automatically 0 while pix_en is low. vWrap already implies
    // hWrap; it is only true when the row wraps on a line wrap.
    always_comb begin
        col_d        = hCntNxt;
        row_d        = vCntNxt;
        hsync_d      = ~hSyncNxt;
        vsync_d      = ~vSyncNxt;
        active_d     = hActNxt & vActNxt;
        line_tick_d  = hWrap;
        frame_tick_d = hWrap & vWrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            active_q     <= 1'b1;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            active_q     <= active_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign scan.col        = col_q;
    assign scan.row        = row_q;
    assign scan.hsync      = hsync_q;
    assign scan.vsync      = vsync_q;
    assign scan.active     = active_q;
    assign scan.line_tick  = line_tick_q;
    assign scan.frame_tick = frame_tick_q;

`ifdef SCAN_TILE_EN
    logic [TILE_W-1:0] tile_col_q, tile_col_d, tile_row_q, tile_row_d;
    logic              tile_start_q, tile_start_d;

    // Tile outputs come from the same next-state values as col/row, so a
    // tile boundary is flagged in the very cycle its first pixel is shown.
    always_comb begin
        tile_col_d   = col_d[COORD_W-1:3];
        tile_row_d   = row_d[COORD_W-1:3];
        tile_start_d = active_d & (col_d[2:0] == 3'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_col_q   <= '0;
            tile_row_q   <= '0;
            tile_start_q <= 1'b1;
        end else begin
            tile_col_q   <= tile_col_d;
            tile_row_q   <= tile_row_d;
            tile_start_q <= tile_start_d;
        end
    end

    assign scan.tile_col   = tile_col_q;
    assign scan.tile_row   = tile_row_q;
    assign scan.tile_start = tile_start_q;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl
//
// Drives two controllers: one with the default 640x480 timing for line
// level behaviour, one with a tiny geometry so whole frames fit in a short
// run. The reference treats the scan as a single linear pixel index
// modulo the frame size; col/row, syncs, active and ticks are derived from
// that index with plain arithmetic.
// Optional feature macro: SCAN_TILE_EN (tile outputs are also checked).

module tb_vga_scan_ctrl;
    import vga_scan_pkg::*;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } geom_t;

    localparam geom_t GBIG   = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam geom_t GSMALL = '{8, 2, 3, 3, 6, 2, 2, 3};

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   posBig;
    int   posSmall;

    vga_scan_ctrl_if bigIf ();
    vga_scan_ctrl_if smallIf ();

    vga_scan_ctrl dutBig (
        .clk  (clk),
        .rst  (rst),
        .scan (bigIf)
    );

    vga_scan_ctrl #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) dutSmall (
        .clk  (clk),
        .rst  (rst),
        .scan (smallIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int htot(input geom_t g);
        return g.ha + g.hf + g.hs + g.hb;
    endfunction

    function automatic int ftot(input geom_t g);
        return htot(g) * (g.va + g.vf + g.vs + g.vb);
    endfunction

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Compares one controller against the linear-index reference. tickOk is
    // low whenever the clock did not advance the scan (reset or no enable).
    task automatic checkScan(input string who, input geom_t g, input int pos,
                             input logic tickOk, input logic [15:0] col,
                             input logic [15:0] row, input logic hs,
                             input logic vs, input logic act, input logic lt,
                             input logic ft);
        int x;
        int y;
        logic expHs;
        logic expVs;
        logic expAct;
        x      = pos % htot(g);
        y      = pos / htot(g);
        expHs  = !(x >= g.ha + g.hf && x < g.ha + g.hf + g.hs);
        expVs  = !(y >= g.va + g.vf && y < g.va + g.vf + g.vs);
        expAct = (x < g.ha) && (y < g.va);
        checkOutput({who, "_col"}, 32'(col), 32'(x));
        checkOutput({who, "_row"}, 32'(row), 32'(y));
        checkOutput({who, "_hsync"}, 32'(hs), 32'(expHs));
        checkOutput({who, "_vsync"}, 32'(vs), 32'(expVs));
        checkOutput({who, "_active"}, 32'(act), 32'(expAct));
        checkOutput({who, "_lineTick"}, 32'(lt), 32'(tickOk && x == 0));
        checkOutput({who, "_frameTick"}, 32'(ft), 32'(tickOk && pos == 0));
    endtask

`ifdef SCAN_TILE_EN
    task automatic checkTile(input string who, input geom_t g, input int pos,
                             input logic [12:0] tc, input logic [12:0] tr,
                             input logic ts);
        int x;
        int y;
        x = pos % htot(g);
        y = pos / htot(g);
        checkOutput({who, "_tileCol"}, 32'(tc), 32'(x / 8));
        checkOutput({who, "_tileRow"}, 32'(tr), 32'(y / 8));
        checkOutput({who, "_tileStart"}, 32'(ts),
                    32'((x < g.ha) && (y < g.va) && (x % 8 == 0)));
    endtask
`endif

    task automatic checkBoth(input logic tickOk);
        checkScan("big", GBIG, posBig, tickOk, bigIf.col, bigIf.row, bigIf.hsync,
                  bigIf.vsync, bigIf.active, bigIf.line_tick, bigIf.frame_tick);
        checkScan("small", GSMALL, posSmall, tickOk, smallIf.col, smallIf.row,
                  smallIf.hsync, smallIf.vsync, smallIf.active, smallIf.line_tick,
                  smallIf.frame_tick);
`ifdef SCAN_TILE_EN
        checkTile("big", GBIG, posBig, bigIf.tile_col, bigIf.tile_row, bigIf.tile_start);
        checkTile("small", GSMALL, posSmall, smallIf.tile_col, smallIf.tile_row,
                  smallIf.tile_start);
`endif
    endtask

    // One clock on the default controller with the given enable.
    task automatic applyStimulus(input logic en);
        bigIf.pix_en = en;
        @(posedge clk);
        #1;
        if (en) posBig = (posBig + 1) % ftot(GBIG);
        checkScan("big", GBIG, posBig, en, bigIf.col, bigIf.row, bigIf.hsync,
                  bigIf.vsync, bigIf.active, bigIf.line_tick, bigIf.frame_tick);
`ifdef SCAN_TILE_EN
        checkTile("big", GBIG, posBig, bigIf.tile_col, bigIf.tile_row, bigIf.tile_start);
`endif
    endtask

    task automatic stepSmall(input logic en);
        smallIf.pix_en = en;
        @(posedge clk);
        #1;
        if (en) posSmall = (posSmall + 1) % ftot(GSMALL);
        checkScan("small", GSMALL, posSmall, en, smallIf.col, smallIf.row,
                  smallIf.hsync, smallIf.vsync, smallIf.active, smallIf.line_tick,
                  smallIf.frame_tick);
`ifdef SCAN_TILE_EN
        checkTile("small", GSMALL, posSmall, smallIf.tile_col, smallIf.tile_row,
                  smallIf.tile_start);
`endif
    endtask

    // Random enables (about 3 in 4) until the default controller reaches
    // the target index; an exhausted budget shows up as a position mismatch.
    task automatic runBigTo(input int target, input int limit);
        int n;
        logic en;
        n = 0;
        while (posBig != target && n < limit) begin
            en = ($urandom_range(0, 3) != 0);
            applyStimulus(en);
            n++;
        end
        checkOutput("bigReachCol", 32'(bigIf.col), 32'(target % htot(GBIG)));
        checkOutput("bigReachRow", 32'(bigIf.row), 32'(target / htot(GBIG)));
    endtask

    initial begin
        int   frames;
        int   n;
        logic en;
        checks   = 0;
        errors   = 0;
        posBig   = 0;
        posSmall = 0;
        rst            = 1'b1;
        bigIf.pix_en   = 1'b1;
        smallIf.pix_en = 1'b1;

        // Reset dominates a held-high enable.
        repeat (3) begin
            @(posedge clk);
            #1;
            checkBoth(1'b0);
        end

        rst            = 1'b0;
        smallIf.pix_en = 1'b0;
        applyStimulus(1'b1);

        // Freeze at col=300, then resume.
        runBigTo(300, 5000);
        repeat (37) applyStimulus(1'b0);
        applyStimulus(1'b1);

        // Through several line wraps to (412, 9), then reset mid-cycle.
        runBigTo(9 * htot(GBIG) + 412, 20000);
        #2;
        rst = 1'b1;
        #1;
        posBig   = 0;
        posSmall = 0;
        checkBoth(1'b0);
        @(posedge clk);
        #1;
        checkBoth(1'b0);
        rst = 1'b0;
        applyStimulus(1'b1);
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 3) != 0);
            applyStimulus(en);
        end
        bigIf.pix_en = 1'b0;

        // Small geometry: three complete frames with random enables.
        frames = 0;
        n      = 0;
        while (frames < 3 && n < 3000) begin
            en = ($urandom_range(0, 3) != 0);
            stepSmall(en);
            if (en && posSmall == 0) frames++;
            n++;
        end
        checkOutput("smallFramesInBudget", 32'(n < 3000), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
